regfile_mp: RTL and testbench

Parametrised multi-port integer register file with write-first internal forwarding and a per-register pending-write scoreboard. It replaces the single-write, two-read register file in the BearCore-V core. It serves pipelines that retire from two writeback sources (ALU and load/CSR) and need hazard stall information. Reads are combinational. Writes, scoreboard state and the pending counter update on the rising edge of `clk`.

---
 rtl/regfile_mp.sv | 84 ++++++++
 tb/tb_regfile_mp.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports (port 1 has priority), write-first
// forwarding on every read port, and a per-register pending-write scoreboard with a busy count.
module regfile_mp #(
  parameter int               XLEN    = 32,
  parameter int               NREGS   = 32,
  parameter int               NRD     = 2,
  parameter int               SP_IDX  = 2,
  parameter logic [XLEN-1:0]  SP_INIT = 32'h0000_8000,
  localparam int              AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                wen0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                wen1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                mark_en,
  input  logic [AW-1:0]       mark_addr,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_we0;
  logic             w_we1;

  assign w_we0 = wen0 && (waddr0 != '0);
  assign w_we1 = wen1 && (waddr1 != '0);

  // A new reservation supersedes a retiring producer, so mark wins over clear.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 1; r < NREGS; r++) begin
      if (mark_en && (mark_addr == AW'(r)))
        w_busy_nxt[r] = 1'b1;
      else if ((w_we0 && (waddr0 == AW'(r))) || (w_we1 && (waddr1 == AW'(r))))
        w_busy_nxt[r] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // NOTE: the whole array is reset here because the architecture defines reset register
  // contents (SP gets a non-zero value); a plain storage array would normally skip reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        r_mem[i] <= (i == SP_IDX) ? SP_INIT : '0;
      r_busy   <= '0;
      pend_cnt <= '0;
    end else begin
      if (w_we0)
        r_mem[waddr0] <= wdata0;
      // Port 1 is assigned last, so on an address collision its data is what gets stored.
      if (w_we1)
        r_mem[waddr1] <= wdata1;
      r_busy   <= w_busy_nxt;
      pend_cnt <= (AW+1)'($countones(w_busy_nxt));
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_a;
    logic          w_hit0;
    logic          w_hit1;

    assign w_a    = raddr[k*AW +: AW];
    assign w_hit0 = wen0 && (waddr0 == w_a);
    assign w_hit1 = wen1 && (waddr1 == w_a);

    assign rdata[k*XLEN +: XLEN] = (w_a == '0) ? '0     :
                                   w_hit1      ? wdata1 :
                                   w_hit0      ? wdata0 : r_mem[w_a];

    // A write arriving this cycle is forwarded, so the reader need not stall on it.
    assign rbusy[k] = (w_a != '0) && r_busy[w_a] && !w_hit0 && !w_hit1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp: forwarding, priority, register 0,
// scoreboard mark/clear behaviour and asynchronous mid-operation reset.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*AW-1:0] raddr;
  logic [63:0]     rdata;
  logic [1:0]      rbusy;
  logic            wen0, wen1, mark_en;
  logic [AW-1:0]   waddr0, waddr1, mark_addr;
  logic [XLEN-1:0] wdata0, wdata1;
  logic [AW:0]     pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_mp dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .mark_en(mark_en), .mark_addr(mark_addr), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            w0;
    logic [AW-1:0]   a0;
    logic [XLEN-1:0] d0;
    logic            w1;
    logic [AW-1:0]   a1;
    logic [XLEN-1:0] d1;
    logic            m;
    logic [AW-1:0]   ma;
    logic [AW-1:0]   r0;
    logic [AW-1:0]   r1;
    logic [XLEN-1:0] e0;
    logic [XLEN-1:0] e1;
    logic [1:0]      eb;
    logic [AW:0]     ep;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(
    input logic w0, input int a0, input logic [31:0] d0,
    input logic w1, input int a1, input logic [31:0] d1,
    input logic m, input int ma, input int r0, input int r1,
    input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb, input int ep);
    vec_t v;
    v.w0 = w0; v.a0 = AW'(a0); v.d0 = d0;
    v.w1 = w1; v.a1 = AW'(a1); v.d1 = d1;
    v.m  = m;  v.ma = AW'(ma);
    v.r0 = AW'(r0); v.r1 = AW'(r1);
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.ep = (AW+1)'(ep);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wen0 = v.w0; waddr0 = v.a0; wdata0 = v.d0;
    wen1 = v.w1; waddr1 = v.a1; wdata1 = v.d1;
    mark_en = v.m; mark_addr = v.ma;
    raddr = {v.r1, v.r0};
  endtask

  // Inputs are applied just after a rising edge; combinational outputs are checked before
  // the next edge and pend_cnt just after it.
  task automatic apply(input vec_t v, input int idx);
    drive(v);
    #1;
    check($sformatf("v%0d rdata0", idx), rdata[31:0],  v.e0);
    check($sformatf("v%0d rdata1", idx), rdata[63:32], v.e1);
    check($sformatf("v%0d rbusy",  idx), 32'(rbusy),   32'(v.eb));
    @(posedge clk);
    #1;
    check($sformatf("v%0d pend_cnt", idx), 32'(pend_cnt), 32'(v.ep));
  endtask

  initial begin
    //             w0 a0  d0           w1 a1  d1          m  ma r0 r1  e0           e1           eb     ep
    tbl[0]  = mk(0, 0,  0,            0, 0,  0,           0, 0, 0, 2,  0,           32'h8000,    2'b00, 0);
    tbl[1]  = mk(1, 7,  32'h11,       1, 7,  32'h22,      0, 0, 7, 7,  32'h22,      32'h22,      2'b00, 0);
    tbl[2]  = mk(0, 0,  0,            0, 0,  0,           0, 0, 7, 7,  32'h22,      32'h22,      2'b00, 0);
    tbl[3]  = mk(1, 0,  32'hDEAD,     1, 0,  32'hDEAD,    1, 0, 0, 0,  0,           0,           2'b00, 0);
    tbl[4]  = mk(0, 0,  0,            0, 0,  0,           0, 0, 0, 7,  0,           32'h22,      2'b00, 0);
    tbl[5]  = mk(0, 0,  0,            0, 0,  0,           1, 5, 5, 5,  0,           0,           2'b00, 1);
    tbl[6]  = mk(0, 0,  0,            0, 0,  0,           0, 0, 5, 2,  0,           32'h8000,    2'b01, 1);
    tbl[7]  = mk(1, 5,  32'hA5,       0, 0,  0,           0, 0, 5, 5,  32'hA5,      32'hA5,      2'b00, 0);
    tbl[8]  = mk(0, 0,  0,            0, 0,  0,           0, 0, 5, 7,  32'hA5,      32'h22,      2'b00, 0);
    tbl[9]  = mk(0, 0,  0,            0, 0,  0,           1, 9, 9, 9,  0,           0,           2'b00, 1);
    tbl[10] = mk(0, 0,  0,            1, 9,  32'h99,      1, 9, 9, 9,  32'h99,      32'h99,      2'b00, 1);
    tbl[11] = mk(0, 0,  0,            0, 0,  0,           0, 0, 9, 9,  32'h99,      32'h99,      2'b11, 1);
    tbl[12] = mk(1, 10, 32'h1010,     0, 0,  0,           0, 0, 10, 9, 32'h1010,    32'h99,      2'b10, 1);
    tbl[13] = mk(1, 9,  32'h55,       1, 9,  32'h66,      0, 0, 9, 10, 32'h66,      32'h1010,    2'b00, 0);
    tbl[14] = mk(0, 0,  0,            0, 0,  0,           0, 0, 9, 10, 32'h66,      32'h1010,    2'b00, 0);
    tbl[15] = mk(1, 10, 32'h77,       0, 0,  0,           0, 0, 10, 10, 32'h77,     32'h77,      2'b00, 0);
    tbl[16] = mk(0, 0,  0,            0, 0,  0,           1, 3, 3, 10, 0,           32'h77,      2'b00, 1);
    tbl[17] = mk(0, 0,  0,            0, 0,  0,           1, 3, 3, 0,  0,           0,           2'b01, 1);
    tbl[18] = mk(0, 0,  0,            0, 0,  0,           1, 4, 3, 4,  0,           0,           2'b01, 2);
    tbl[19] = mk(0, 0,  0,            0, 0,  0,           1, 6, 3, 4,  0,           0,           2'b11, 3);

    // Reset state
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 2'b00, 0));
    @(posedge clk);
    #2;
    check("reset rdata0 r0", rdata[31:0],  32'h0);
    check("reset rdata1 r2", rdata[63:32], 32'h8000);
    check("reset rbusy",     32'(rbusy),   32'h0);
    check("reset pend_cnt",  32'(pend_cnt), 32'h0);
    raddr = {AW'(5), AW'(5)};
    #1;
    check("reset rdata r5",  rdata[31:0],  32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++)
      apply(tbl[i], i);

    // Asynchronous reset pulse between edges, with registers 3, 4 and 6 busy
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 0, 0, 2'b00, 0));
    #1;
    check("pre-reset rbusy", 32'(rbusy), 32'h3);
    #1;
    rst = 1'b1;
    #1;
    check("async rst pend_cnt", 32'(pend_cnt), 32'h0);
    check("async rst rbusy",    32'(rbusy),    32'h0);
    raddr = {AW'(6), AW'(2)};
    #1;
    check("async rst r2 = SP_INIT", rdata[31:0], 32'h8000);
    check("async rst rbusy r6",     32'(rbusy),  32'h0);
    raddr = {AW'(9), AW'(7)};
    #1;
    check("async rst r7 cleared", rdata[31:0],  32'h0);
    check("async rst r9 cleared", rdata[63:32], 32'h0);

    // Writes and marks while reset is held: forwarded, but never committed
    drive(mk(1, 11, 32'hBEEF, 0, 0, 0, 1, 11, 11, 11, 0, 0, 2'b00, 0));
    #1;
    check("rst fwd rdata", rdata[31:0], 32'hBEEF);
    check("rst fwd rbusy", 32'(rbusy),  32'h0);
    @(posedge clk);
    #1;
    check("rst held pend_cnt", 32'(pend_cnt), 32'h0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 11, 11, 0, 0, 2'b00, 0));
    #1;
    check("rst write ignored", rdata[31:0], 32'h0);

    // First edge after release updates normally
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 1, 12, 12, 12, 0, 0, 2'b00, 0));
    @(posedge clk);
    #1;
    check("release pend_cnt", 32'(pend_cnt), 32'h1);
    mark_en = 1'b0;
    #1;
    check("release rbusy r12", 32'(rbusy), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
